// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the round-robin interval timer arbiter.
// Provides the FSM state encoding and the masked round-robin pick.
package timer_arbiter_pkg;

  localparam int kNumReqDef  = 4;
  localparam int kTickDivDef = 50000;
  localparam int kDurWDef    = 16;
  localparam int kIdxW       = 3;
  localparam int kReqMax     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // First set request at or after ptr, wrapping at n.
  function automatic logic [kIdxW-1:0] rr_pick(
    input logic [kReqMax-1:0] req,
    input logic [kIdxW-1:0]   ptr,
    input int                 n
  );
    logic [kIdxW-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int i = 0; i < kReqMax; i++) begin
      if (i < n) begin
        if (!found && req[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
        idx = (int'(idx) == n - 1) ? '0 : idx + 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/timer_arbiter_prescaler.sv
// Coarse tick prescaler: counts 0..kTickDiv-1 while enabled.
// tick is high on the last count of each period.
module tick_prescaler #(
  parameter int kTickDiv = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int kW = (kTickDiv > 1) ? $clog2(kTickDiv) : 1;
  localparam logic [kW-1:0] kLast = kW'(kTickDiv - 1);

  logic [kW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == kLast) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == kLast);

endmodule

// File: rtl/timer_arbiter.sv
// One interval timer shared round-robin among kNumReq requesters.
// Grants, counts the owner's duration in ticks, pulses done.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int kNumReq  = kNumReqDef,
  parameter int kTickDiv = kTickDivDef,
  parameter int kDurW    = kDurWDef
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [kNumReq-1:0]       req,
  input  logic [kNumReq*kDurW-1:0] dur,
  output logic [kNumReq-1:0]       grant,
  output logic [kNumReq-1:0]       done,
  output logic                     busy,
  output logic                     tick
);

  localparam logic [kNumReq-1:0] kOne =
    {{(kNumReq-1){1'b0}}, 1'b1};

  state_e             state;
  logic [kIdxW-1:0]   ptr;
  logic [kIdxW-1:0]   owner;
  logic [kIdxW-1:0]   pick;
  logic [kIdxW-1:0]   owner_nxt;
  logic [kReqMax-1:0] req_pad;
  logic [kDurW-1:0]   dur_sel;
  logic [kDurW-1:0]   remain;
  logic               owner_req;
  logic               load;
  logic               pre_tick;

  always_comb begin
    req_pad = '0;
    req_pad[kNumReq-1:0] = req;
  end

  assign pick      = rr_pick(req_pad, ptr, kNumReq);
  assign dur_sel   = dur[int'(pick)*kDurW +: kDurW];
  assign owner_req = req_pad[owner];
  assign load      = (state == ST_IDLE) && (|req);
  assign owner_nxt =
    (int'(owner) == kNumReq - 1) ? '0 : owner + 1'b1;

  tick_prescaler #(
    .kTickDiv(kTickDiv)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (state == ST_RUN),
    .tick(pre_tick)
  );

  assign tick = busy & pre_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      ptr    <= '0;
      owner  <= '0;
      remain <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= '0;
          if (load) begin
            owner  <= pick;
            grant  <= kOne << pick;
            busy   <= 1'b1;
            remain <= (dur_sel == '0) ? kDurW'(1) : dur_sel;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A dropped request beats a simultaneous final wrap.
          if (!owner_req) begin
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= owner_nxt;
            state <= ST_IDLE;
          end else if (pre_tick) begin
            remain <= remain - 1'b1;
            if (remain == kDurW'(1)) begin
              grant <= '0;
              busy  <= 1'b0;
              done  <= kOne << owner;
              ptr   <= owner_nxt;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done  <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares one programmable interval timer among `kNumReq` requesters (gate-open hold, display blink, fee-period counter, etc.) in the parking-lot controller. A round-robin arbiter grants the timer to one requester at a time. The block loads that requester's duration, counts it in coarse ticks derived from the 50 MHz system clock, and returns a one-cycle completion pulse. Replaces one free-running divider per consumer with a single sequenced resource.

## Interface
- `kNumReq`, default 4: number of requesters (2..8).
- `kTickDiv`, default 50000: system clocks per tick (1 ms at 50 MHz); must be ≥ 2.
- `kDurW`, default 16: width of each duration field, in ticks.
- `clk`  in  1: 50 MHz system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  kNumReq: level request per requester; held until `done` or abandoned.
- `dur`  in  kNumReq*kDurW: packed durations; requester i uses `dur[i*kDurW +: kDurW]`. Sampled only on the grant cycle.
- `grant`  out  kNumReq: one-hot, registered; high while requester i owns the timer.
- `done`  out  kNumReq: one-cycle completion pulse to the owner.
- `busy`  out  1: timer owned (state RUN).
- `tick`  out  1: one-cycle pulse per elapsed tick while RUN (debug/LED use).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE:
  - If any `req` is high, select the winner round-robin, starting from `ptr`.
  - Next cycle: `grant[w]`=1, `remain`←`dur[w]`, prescaler←0, state RUN.
  - `dur`=0 is treated as 1.
- RUN:
  - Prescaler counts 0..kTickDiv-1 and wraps.
  - At the wrap cycle: `tick`=1, and `remain` decrements.
  - If `remain`==1 at a wrap: state DONE and `grant` clears.
- DONE:
  - `done[w]`=1 for exactly one cycle.
  - `ptr`←(w+1) mod kNumReq.
  - State → IDLE.
- Abandon: `req[w]` low during RUN → IDLE next cycle.
  - `grant` clears; no `done` pulse.
  - `ptr`←(w+1) mod kNumReq.
- `req` of non-owners is ignored during RUN/DONE.
  - Requests stay pending and are arbitrated in the next IDLE.
- Requester still holding `req` after its `done`:
  - Treated as a new request.
  - Has lowest priority due to the `ptr` advance.
- Reset mid-RUN or mid-DONE:
  - Aborts immediately.
  - No `done` pulse.
  - `ptr`←0.
- Arithmetic:
  - Prescaler is `$clog2(kTickDiv)` bits; compare against kTickDiv-1, never relies on overflow.
  - `remain` is kDurW bits, unsigned.

## Timing
- Reset values: `grant`=0, `done`=0, `busy`=0, `tick`=0, `ptr`=0, `remain`=0, prescaler=0, state IDLE.
- `req` seen in IDLE at cycle t → `grant`/`busy` high at t+1 (call it G).
- `grant` high for cycles G .. G+D·kTickDiv−1, where D = max(dur,1).
- `done` pulse at G+D·kTickDiv; state IDLE at G+D·kTickDiv+1.
- Earliest next grant is G+D·kTickDiv+2.
- `tick` pulses at G+n·kTickDiv−1, for n=1..D.
- Simultaneous final wrap and owner `req` drop: drop wins (abandon, no `done`).
- All outputs are registered; no combinational path from `req` to `grant`.

## Structure
- Package `timer_arbiter_pkg`:
  - State enum (IDLE/RUN/DONE).
  - Default localparams for kNumReq, kTickDiv, kDurW.
  - Round-robin pick function (masked priority by `ptr`, wrap-around).
- Sub-module `tick_prescaler` (parameter kTickDiv):
  - Ports `clk`, `rst`, `clr`, `en`, `tick`.
  - Counts while `en`; `clr` zeroes the count.
  - `tick` asserted when count==kTickDiv−1.
- Top holds the FSM, `ptr`, `remain`, the grant register and the `dur` mux.

## Test plan
- Test parameters: kTickDiv=4, kNumReq=4, kDurW=8.
- Single request:
  - Stimulus: `req`=0001, `dur0`=3 at cycle 10.
  - Required: `grant`=0001 on cycles 11..22; `tick` on 14, 18, 22; `done`=0001 on cycle 23; IDLE on 24.
- Zero duration:
  - Stimulus: `dur0`=0.
  - Required: `done` exactly 4 cycles after the grant rise.
- Round-robin:
  - Stimulus: `req`=1111 held after each `done`, all `dur`=1.
  - Required: grants in order 0,1,2,3,0; each grant starts 2 cycles after the previous `done`.
- Abandon:
  - Stimulus: requester 2 granted with `dur`=5; `req2` drops after 7 cycles.
  - Required: `grant` clears next cycle; no `done`; `req1` pending → `grant`=1000? No — next winner is 3 if pending, else wraps to 1.
- Reset mid-RUN:
  - Stimulus: `rst` pulsed 6 cycles into a grant.
  - Required: all outputs 0 next cycle; no `done`; `ptr`=0, so `req`=0011 then grants requester 0.
- Edge collision:
  - Stimulus: owner drops `req` on the same cycle as the final wrap.
  - Required: no `done` pulse; IDLE next cycle.
